// File: rtl/upe_seq_ctrl.sv
// Sequenced uncertainty-propagation engine:
// var_z = var_x*dfdx^2 + 2*covar_xy*dfdx*dfdy + var_y*dfdy^2.
// One 16x16 multiplier and one 64-bit accumulator are shared across a fixed schedule.
module upe_seq_ctrl #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] var_x,
  input  logic [15:0] var_y,
  input  logic [15:0] covar_xy,
  input  logic [15:0] dfdx,
  input  logic [15:0] dfdy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] var_z,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_SQX, S_MXL, S_MXH, S_SQY, S_MYL, S_MYH, S_XY, S_MCL, S_MCH, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] vx_q, vx_d, vy_q, vy_d, cov_q, cov_d, dx_q, dx_d, dy_q, dy_d;
  logic        sgn_q, sgn_d;
  logic [31:0] tmp_q, tmp_d;
  logic [63:0] acc_q, acc_d, var_z_q, var_z_d;

  logic [15:0] mul_a, mul_b;
  logic [31:0] prod;
  logic [63:0] term;
  logic [15:0] sdx, sdy, scov;
  logic        do_x, do_y, do_c;

  function automatic logic [15:0] mag(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

  assign prod = 32'(mul_a) * 32'(mul_b);

  // Skip decisions use the live operands at acceptance, captured magnitudes afterwards.
  assign sdx  = (state_q == S_IDLE) ? mag(dfdx)     : dx_q;
  assign sdy  = (state_q == S_IDLE) ? mag(dfdy)     : dy_q;
  assign scov = (state_q == S_IDLE) ? mag(covar_xy) : cov_q;
  assign do_x = !SKIP_ZERO || (sdx != 16'd0);
  assign do_y = !SKIP_ZERO || (sdy != 16'd0);
  assign do_c = !SKIP_ZERO || ((sdx != 16'd0) && (sdy != 16'd0) && (scov != 16'd0));

  always_comb begin
    state_d = state_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    cov_d   = cov_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sgn_d   = sgn_q;
    tmp_d   = tmp_q;
    acc_d   = acc_q;
    var_z_d = var_z_q;
    mul_a   = 16'd0;
    mul_b   = 16'd0;
    term    = 64'd0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        vx_d    = var_x;
        vy_d    = var_y;
        cov_d   = mag(covar_xy);
        dx_d    = mag(dfdx);
        dy_d    = mag(dfdy);
        sgn_d   = covar_xy[15] ^ dfdx[15] ^ dfdy[15];
        acc_d   = 64'd0;
        state_d = do_x ? S_SQX : do_y ? S_SQY : do_c ? S_XY : S_DONE;
      end
      S_SQX: begin
        mul_a = dx_q; mul_b = dx_q; tmp_d = prod; state_d = S_MXL;
      end
      S_MXL: begin
        mul_a = vx_q; mul_b = tmp_q[15:0];
        acc_d = acc_q + {32'd0, prod}; state_d = S_MXH;
      end
      S_MXH: begin
        mul_a = vx_q; mul_b = tmp_q[31:16];
        acc_d = acc_q + {16'd0, prod, 16'd0};
        state_d = do_y ? S_SQY : do_c ? S_XY : S_DONE;
      end
      S_SQY: begin
        mul_a = dy_q; mul_b = dy_q; tmp_d = prod; state_d = S_MYL;
      end
      S_MYL: begin
        mul_a = vy_q; mul_b = tmp_q[15:0];
        acc_d = acc_q + {32'd0, prod}; state_d = S_MYH;
      end
      S_MYH: begin
        mul_a = vy_q; mul_b = tmp_q[31:16];
        acc_d = acc_q + {16'd0, prod, 16'd0};
        state_d = do_c ? S_XY : S_DONE;
      end
      S_XY: begin
        mul_a = dx_q; mul_b = dy_q; tmp_d = prod; state_d = S_MCL;
      end
      S_MCL: begin
        mul_a = cov_q; mul_b = tmp_q[15:0];
        term  = {31'd0, prod, 1'b0};
        acc_d = sgn_q ? acc_q - term : acc_q + term;
        state_d = S_MCH;
      end
      S_MCH: begin
        mul_a = cov_q; mul_b = tmp_q[31:16];
        term  = {15'd0, prod, 17'd0};
        acc_d = sgn_q ? acc_q - term : acc_q + term;
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && state_q != S_DONE) var_z_d = acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vx_q    <= 16'd0;
      vy_q    <= 16'd0;
      cov_q   <= 16'd0;
      dx_q    <= 16'd0;
      dy_q    <= 16'd0;
      sgn_q   <= 1'b0;
      tmp_q   <= 32'd0;
      acc_q   <= 64'd0;
      var_z_q <= 64'd0;
    end else begin
      state_q <= state_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      cov_q   <= cov_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sgn_q   <= sgn_d;
      tmp_q   <= tmp_d;
      acc_q   <= acc_d;
      var_z_q <= var_z_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign var_z     = var_z_q;

endmodule

// File: tb/tb_upe_seq_ctrl.sv
// Bench for upe_seq_ctrl: SKIP_ZERO=1 (index 0) and SKIP_ZERO=0 (index 1) run side by side
// against a cycle-level result/latency model, plus directed literal cases.
module tb_upe_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [15:0] var_x, var_y, covar_xy, dfdx, dfdy;
  logic [1:0]  ir, ov, bz;
  logic [63:0] z [2];

  int total = 0, bad = 0;

  upe_seq_ctrl #(.SKIP_ZERO(1'b1)) u_skip (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .var_x(var_x), .var_y(var_y), .covar_xy(covar_xy), .dfdx(dfdx), .dfdy(dfdy),
    .out_valid(ov[0]), .out_ready(out_ready), .var_z(z[0]), .busy(bz[0]));

  upe_seq_ctrl #(.SKIP_ZERO(1'b0)) u_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .var_x(var_x), .var_y(var_y), .covar_xy(covar_xy), .dfdx(dfdx), .dfdy(dfdy),
    .out_valid(ov[1]), .out_ready(out_ready), .var_z(z[1]), .busy(bz[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_z(input logic [15:0] a, dx, b, dy, c);
    longint x  = longint'($signed(dx));
    longint y  = longint'($signed(dy));
    longint cv = longint'($signed(c));
    longint va = longint'(a);
    longint vb = longint'(b);
    return 64'(va * x * x + 2 * cv * x * y + vb * y * y);
  endfunction

  function automatic int ref_lat(input bit skip, input logic [15:0] dx, dy, c);
    int n;
    if (!skip) return 10;
    n = 1;
    if (dx != 0) n += 3;
    if (dy != 0) n += 3;
    if (dx != 0 && dy != 0 && c != 0) n += 3;
    return n;
  endfunction

  // Model: 0 idle, 1 computing (m_cnt edges left), 2 holding a result.
  int          m_st [2];
  int          m_cnt[2];
  int          mn;
  logic [63:0] m_z  [2];
  logic [63:0] m_res[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_st[d] = 0;
        m_z[d]  = 64'd0;
      end else begin
        case (m_st[d])
          0: if (in_valid) begin
            m_res[d] = ref_z(var_x, dfdx, var_y, dfdy, covar_xy);
            mn = ref_lat(d == 0, dfdx, dfdy, covar_xy);
            if (mn == 1) begin
              m_st[d] = 2;
              m_z[d]  = m_res[d];
            end else begin
              m_st[d]  = 1;
              m_cnt[d] = mn - 1;
            end
          end
          1: begin
            m_cnt[d]--;
            if (m_cnt[d] == 0) begin
              m_st[d] = 2;
              m_z[d]  = m_res[d];
            end
          end
          default: if (out_ready) m_st[d] = 0;
        endcase
      end
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("in_ready[%0d]", d), 64'(ir[d]), 64'(m_st[d] == 0));
      chk($sformatf("busy[%0d]", d), 64'(bz[d]), 64'(m_st[d] != 0));
      chk($sformatf("out_valid[%0d]", d), 64'(ov[d]), 64'(m_st[d] == 2));
      chk($sformatf("var_z[%0d]", d), z[d], m_z[d]);
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (ir != 2'b11 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ir != 2'b11) chk("wait_idle_timeout", 64'(ir), 64'd3);
  endtask

  task automatic set_ops(input logic [15:0] a, dx, b, dy, c);
    var_x = a; dfdx = dx; var_y = b; dfdy = dy; covar_xy = c;
  endtask

  task automatic run_case(input string nm, input logic [15:0] a, dx, b, dy, c,
                          input logic [63:0] exp_z, input int l0, input int l1);
    int lat [2];
    logic [63:0] got [2];
    lat = '{0, 0};
    got = '{64'd0, 64'd0};
    wait_idle();
    set_ops(a, dx, b, dy, c);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++)
        if (ov[d] && lat[d] == 0) begin
          lat[d] = k;
          got[d] = z[d];
        end
      if (lat[0] != 0 && lat[1] != 0) break;
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_lat_skip"}, 64'(lat[0]), 64'(l0));
    chk({nm, "_lat_full"}, 64'(lat[1]), 64'(l1));
    chk({nm, "_z_skip"}, got[0], exp_z);
    chk({nm, "_z_full"}, got[1], exp_z);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0, 1: return 16'h0000;
      2: return 16'h8000;
      3: return 16'hFFFF;
      4: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_ops(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 64'(ir[d]), 64'd1);
      chk("rst_busy", 64'(bz[d]), 64'd0);
      chk("rst_out_valid", 64'(ov[d]), 64'd0);
      chk("rst_var_z", z[d], 64'd0);
    end

    run_case("basic", 16'd4, 16'd3, 16'd9, 16'hFFFE, 16'd5, 64'd12, 10, 10);
    run_case("dy_zero", 16'd100, 16'hFFF9, 16'd500, 16'd0, 16'd123, 64'd4900, 4, 10);
    run_case("all_zero", 16'($urandom), 16'd0, 16'($urandom), 16'd0, 16'($urandom),
             64'd0, 1, 10);
    run_case("extreme", 16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000,
             64'h0000_3FFF_8000_0000, 10, 10);

    // Output stall with ignored in_valid pulses, then a fresh accept.
    wait_idle();
    set_ops(16'd4, 16'd3, 16'd9, 16'hFFFE, 16'd5);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (ov != 2'b11 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_done", 64'(ov), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      #1;
      chk("stall_ov", 64'(ov), 64'd3);
      chk("stall_z0", z[0], 64'd12);
      chk("stall_z1", z[1], 64'd12);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("stall_release_idle", 64'(ir), 64'd3);
    run_case("after_stall", 16'd100, 16'hFFF9, 16'd500, 16'd0, 16'd123, 64'd4900, 4, 10);

    // Reset while both instances sit in MYL.
    wait_idle();
    set_ops(16'd4, 16'd3, 16'd9, 16'hFFFE, 16'd5);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ov", 64'(ov), 64'd0);
    chk("midrst_busy", 64'(bz), 64'd0);
    chk("midrst_z0", z[0], 64'd0);
    chk("midrst_z1", z[1], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_case("after_rst", 16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000,
             64'h0000_3FFF_8000_0000, 10, 10);

    // Random traffic; the model process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (ir == 2'b11) begin
        in_valid = ($urandom_range(0, 2) != 0);
        set_ops(rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
      end else if (ir == 2'b00) begin
        in_valid = 1'($urandom_range(0, 1));
        set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
